// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front end: key codes, menu option
// codes, field limits and the front-end state encoding.
package atm_pkg;

  localparam int ACC_W = 14;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam logic [2:0] OPT_BALANCE               = 3'd3;
  localparam logic [2:0] OPT_WITHDRAW              = 3'd4;
  localparam logic [2:0] OPT_WITHDRAW_SHOW_BALANCE = 3'd5;
  localparam logic [2:0] OPT_TRANSACTION           = 3'd6;
  localparam logic [2:0] OPT_DEPOSIT               = 3'd7;

  localparam logic [ACC_W-1:0] ACC_MAX    = 14'd4095;
  localparam logic [ACC_W-1:0] AMOUNT_MAX = 14'd2047;
  localparam logic [ACC_W-1:0] PIN_MAX    = 14'd9;
  localparam logic [ACC_W-1:0] MENU_MIN   = 14'd3;
  localparam logic [ACC_W-1:0] MENU_MAX   = 14'd7;

  localparam logic [2:0] FIELD_DIGITS  = 3'd4;
  localparam logic [2:0] SINGLE_DIGITS = 3'd1;

  typedef enum logic [2:0] {
    S_ACC    = 3'd0,
    S_PIN    = 3'd1,
    S_MENU   = 3'd2,
    S_AMOUNT = 3'd3,
    S_DEST   = 3'd4,
    S_ISSUE  = 3'd5
  } fe_state_e;

endpackage

// File: rtl/decimal_accumulator.sv
// Multi-digit decimal entry register: value = value*10 + digit, with a
// per-field digit limit. Clear has priority over a digit on the same edge.
module decimal_accumulator
  import atm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             clear,
  input  logic [2:0]       max_digits,
  output logic [ACC_W-1:0] value,
  output logic [2:0]       digit_count,
  output logic             overflow
);

  logic [ACC_W-1:0] value_next;

  assign value_next = value * 14'd10 + {10'd0, digit};
  // Overflow means a further digit would exceed the field limit.
  assign overflow   = (digit_count >= max_digits);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value       <= '0;
      digit_count <= '0;
    end else if (digit_valid && !overflow) begin
      value       <= value_next;
      digit_count <= digit_count + 3'd1;
    end
  end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad-to-ATM-core request front end. Define ATM_KEYPAD_TIMEOUT_EN to build
// the idle timeout that forces a session exit after TIMEOUT_CYCLES idle cycles.
module atm_keypad_frontend
  import atm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        req_ready,
  output logic [11:0] acc_number,
  output logic [3:0]  pin,
  output logic [2:0]  menu_option,
  output logic [10:0] amount,
  output logic [11:0] destination_acc,
  output logic        req_valid,
  output logic        exit,
  output logic        entry_error,
  output fe_state_e   state_dbg
);

  // Handshake: a request is transferred on the rising edge where req_valid
  // and req_ready are both high; fields stay frozen while req_valid is high.

  fe_state_e        state;
  logic [ACC_W-1:0] acc_value;
  logic [2:0]       acc_count;
  logic             acc_overflow;
  logic [2:0]       max_digits;
  logic             is_digit, key_enter, key_clear, key_cancel;
  logic             in_issue, cancel_evt, timeout_hit;
  logic             acc_clear, acc_digit, range_ok;

  assign is_digit   = key_valid && (key_code <= 4'd9);
  assign key_enter  = key_valid && (key_code == KEY_ENTER);
  assign key_clear  = key_valid && (key_code == KEY_CLEAR);
  assign key_cancel = key_valid && (key_code == KEY_CANCEL);
  assign in_issue   = (state == S_ISSUE);
  assign cancel_evt = key_cancel || timeout_hit;

  assign acc_clear  = cancel_evt
                   || (!in_issue && (key_enter || key_clear))
                   || (in_issue && req_ready);
  assign acc_digit  = is_digit && !in_issue && !cancel_evt;
  assign max_digits = (state == S_PIN || state == S_MENU) ? SINGLE_DIGITS : FIELD_DIGITS;
  assign state_dbg  = state;

`ifdef ATM_KEYPAD_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        counted;

  assign counted     = (state != S_ACC) && (state != S_ISSUE);
  assign timeout_hit = counted && !key_valid && (idle_cnt == TIMEOUT_CYCLES - 32'd1);

  // Every state change into a counted state coincides with a key or with
  // leaving an uncounted state, so this reload covers state changes too.
  always_ff @(posedge clk) begin
    if (rst || key_valid || !counted || timeout_hit) idle_cnt <= '0;
    else                                             idle_cnt <= idle_cnt + 32'd1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    range_ok = 1'b0;
    case (state)
      S_ACC, S_DEST: range_ok = (acc_value <= ACC_MAX);
      S_PIN:         range_ok = (acc_value <= PIN_MAX);
      S_AMOUNT:      range_ok = (acc_value <= AMOUNT_MAX);
      S_MENU:        range_ok = (acc_value >= MENU_MIN) && (acc_value <= MENU_MAX);
      default:       range_ok = 1'b0;
    endcase
  end

  decimal_accumulator u_acc (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (acc_digit),
    .digit       (key_code),
    .clear       (acc_clear),
    .max_digits  (max_digits),
    .value       (acc_value),
    .digit_count (acc_count),
    .overflow    (acc_overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_ACC;
      acc_number      <= '0;
      pin             <= '0;
      menu_option     <= '0;
      amount          <= '0;
      destination_acc <= '0;
      req_valid       <= 1'b0;
      exit            <= 1'b0;
      entry_error     <= 1'b0;
    end else begin
      exit        <= 1'b0;
      entry_error <= 1'b0;
      if (cancel_evt) begin
        state           <= S_ACC;
        acc_number      <= '0;
        pin             <= '0;
        menu_option     <= '0;
        amount          <= '0;
        destination_acc <= '0;
        req_valid       <= 1'b0;
        exit            <= 1'b1;
      end else if (in_issue) begin
        if (req_ready) begin
          req_valid <= 1'b0;
          state     <= S_MENU;
        end
      end else if (is_digit && acc_overflow) begin
        entry_error <= 1'b1;
      end else if (key_enter) begin
        if (acc_count == 3'd0 || !range_ok) begin
          entry_error <= 1'b1;
        end else begin
          case (state)
            S_ACC: begin
              acc_number <= acc_value[11:0];
              state      <= S_PIN;
            end
            S_PIN: begin
              pin   <= acc_value[3:0];
              state <= S_MENU;
            end
            S_MENU: begin
              menu_option <= acc_value[2:0];
              if (acc_value[2:0] == OPT_BALANCE) begin
                state     <= S_ISSUE;
                req_valid <= 1'b1;
              end else begin
                state <= S_AMOUNT;
              end
            end
            S_AMOUNT: begin
              amount <= acc_value[10:0];
              if (menu_option == OPT_TRANSACTION) begin
                state <= S_DEST;
              end else begin
                state     <= S_ISSUE;
                req_valid <= 1'b1;
              end
            end
            S_DEST: begin
              destination_acc <= acc_value[11:0];
              state           <= S_ISSUE;
              req_valid       <= 1'b1;
            end
            default: state <= S_ACC;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for atm_keypad_frontend; expected requests are queued and
// compared when req_valid is observed.
module tb_atm_keypad_frontend;
  import atm_pkg::*;

`ifdef ATM_KEYPAD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        req_ready;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic [2:0]  menu_option;
  logic [10:0] amount;
  logic [11:0] destination_acc;
  logic        req_valid;
  logic        exit;
  logic        entry_error;
  fe_state_e   state_dbg;

  int vectors     = 0;
  int miscompares = 0;
  logic [41:0] exp_q[$];

  atm_keypad_frontend #(.TIMEOUT_CYCLES(20)) dut (
    .clk             (clk),
    .rst             (rst),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .req_ready       (req_ready),
    .acc_number      (acc_number),
    .pin             (pin),
    .menu_option     (menu_option),
    .amount          (amount),
    .destination_acc (destination_acc),
    .req_valid       (req_valid),
    .exit            (exit),
    .entry_error     (entry_error),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic type_digits(input string s);
    for (int i = 0; i < s.len(); i++) press(4'(s[i] - 8'd48));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_req(input string tag);
    logic [41:0] exp_fields;
    for (int i = 0; i < 4 && req_valid !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_valid"}, 64'(req_valid), 64'd1);
    exp_fields = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk({tag, "_fields"}, 64'({acc_number, pin, menu_option, amount, destination_acc}),
        64'(exp_fields));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_acc"}, 64'(acc_number), 64'd0);
    chk({tag, "_pin"}, 64'(pin), 64'd0);
    chk({tag, "_menu"}, 64'(menu_option), 64'd0);
    chk({tag, "_amount"}, 64'(amount), 64'd0);
    chk({tag, "_dest"}, 64'(destination_acc), 64'd0);
    chk({tag, "_req_valid"}, 64'(req_valid), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    req_ready = 1'b0;
    idle(2);

    // reset state
    chk_all_zero("reset");
    chk("reset_exit", 64'(exit), 64'd0);
    chk("reset_err", 64'(entry_error), 64'd0);
    chk("reset_state", 64'(state_dbg), 64'(S_ACC));
    rst = 1'b0;
    idle(1);

    // login and balance request, ready already high
    type_digits("2749"); press(KEY_ENTER);
    chk("login_state", 64'(state_dbg), 64'(S_PIN));
    chk("login_acc", 64'(acc_number), 64'd2749);
    type_digits("3"); press(KEY_ENTER);
    chk("pin_state", 64'(state_dbg), 64'(S_MENU));
    chk("pin_val", 64'(pin), 64'd3);
    req_ready = 1'b1;
    exp_q.push_back({12'd2749, 4'd3, 3'd3, 11'd0, 12'd0});
    type_digits("3"); press(KEY_ENTER);
    expect_req("balance");
    chk("balance_state", 64'(state_dbg), 64'(S_ISSUE));
    idle(1);
    chk("balance_drop", 64'(req_valid), 64'd0);
    chk("balance_back", 64'(state_dbg), 64'(S_MENU));
    chk("balance_keep_acc", 64'(acc_number), 64'd2749);
    req_ready = 1'b0;

    // transaction with destination
    type_digits("6"); press(KEY_ENTER);
    chk("xfer_state_amt", 64'(state_dbg), 64'(S_AMOUNT));
    type_digits("150"); press(KEY_ENTER);
    chk("xfer_state_dest", 64'(state_dbg), 64'(S_DEST));
    chk("xfer_amount", 64'(amount), 64'd150);
    exp_q.push_back({12'd2749, 4'd3, 3'd6, 11'd150, 12'd2175});
    type_digits("2175"); press(KEY_ENTER);
    expect_req("xfer");
    idle(3);
    chk("xfer_hold", 64'(req_valid), 64'd1);
    type_digits("9");
    chk("xfer_drop_key_state", 64'(state_dbg), 64'(S_ISSUE));
    chk("xfer_frozen_dest", 64'(destination_acc), 64'd2175);
    req_ready = 1'b1;
    idle(1);
    req_ready = 1'b0;
    chk("xfer_accept", 64'(req_valid), 64'd0);
    chk("xfer_back", 64'(state_dbg), 64'(S_MENU));

    // amount range boundary
    type_digits("4"); press(KEY_ENTER);
    type_digits("2048"); press(KEY_ENTER);
    chk("amt2048_err", 64'(entry_error), 64'd1);
    chk("amt2048_state", 64'(state_dbg), 64'(S_AMOUNT));
    chk("amt2048_noreq", 64'(req_valid), 64'd0);
    idle(1);
    chk("amt2048_err_pulse", 64'(entry_error), 64'd0);
    exp_q.push_back({12'd2749, 4'd3, 3'd4, 11'd2047, 12'd2175});
    type_digits("2047"); press(KEY_ENTER);
    expect_req("amt2047");

    // cancel while request pending, ready low
    press(KEY_CANCEL);
    chk("cancel_exit", 64'(exit), 64'd1);
    chk_all_zero("cancel");
    chk("cancel_state", 64'(state_dbg), 64'(S_ACC));
    idle(1);
    chk("cancel_exit_pulse", 64'(exit), 64'd0);

    // account range, digit limit, clear
    type_digits("5000"); press(KEY_ENTER);
    chk("acc5000_err", 64'(entry_error), 64'd1);
    chk("acc5000_state", 64'(state_dbg), 64'(S_ACC));
    type_digits("1234");
    chk("acc4dig_noerr", 64'(entry_error), 64'd0);
    type_digits("5");
    chk("acc5th_err", 64'(entry_error), 64'd1);
    press(KEY_CLEAR);
    type_digits("2125"); press(KEY_ENTER);
    chk("acc2125_state", 64'(state_dbg), 64'(S_PIN));
    chk("acc2125_val", 64'(acc_number), 64'd2125);
    press(KEY_ENTER);
    chk("pin_empty_err", 64'(entry_error), 64'd1);
    chk("pin_empty_state", 64'(state_dbg), 64'(S_PIN));
    type_digits("7"); press(KEY_ENTER);
    type_digits("8"); press(KEY_ENTER);
    chk("menu8_err", 64'(entry_error), 64'd1);
    chk("menu8_state", 64'(state_dbg), 64'(S_MENU));

    // cancel and ready on the same edge: cancel wins
    exp_q.push_back({12'd2125, 4'd7, 3'd3, 11'd0, 12'd0});
    type_digits("3"); press(KEY_ENTER);
    expect_req("bal2");
    req_ready = 1'b1;
    press(KEY_CANCEL);
    req_ready = 1'b0;
    chk("cancel_ready_exit", 64'(exit), 64'd1);
    chk("cancel_ready_state", 64'(state_dbg), 64'(S_ACC));
    chk("cancel_ready_valid", 64'(req_valid), 64'd0);

    // idle timeout in S_MENU
    type_digits("42"); press(KEY_ENTER);
    type_digits("1"); press(KEY_ENTER);
    chk("tmo_menu_state", 64'(state_dbg), 64'(S_MENU));
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("tmo_exit_%0d", i), 64'(exit), 64'(TMO_EN && i == 20));
    end
    chk("tmo_final_state", 64'(state_dbg), TMO_EN ? 64'(S_ACC) : 64'(S_MENU));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/atm_keypad_frontend.md
# atm_keypad_frontend

Request-side front end for the ATM core. It converts a stream of keypad key codes into the parallel session signals the core consumes: account number, PIN, menu option, amount, destination account and exit. It sits between the keypad scanner and the ATM core. It assembles multi-digit decimal entries, range-checks them against the core's port widths, and issues each complete request with a valid/ready handshake.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles before a forced exit (used only with the timeout feature).
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `key_valid` input 1: `key_code` is valid this cycle; one key per high cycle.
- `key_code` input 4: digit keys are 0–9. Control keys are 4'hA ENTER, 4'hB CLEAR and 4'hC CANCEL. Codes D–F are ignored.
- `req_ready` input 1: the core accepts the current request.
- `acc_number` output 12: assembled account number.
- `pin` output 4: assembled PIN digit.
- `menu_option` output 3: selected operation code (3 BALANCE, 4 WITHDRAW, 5 WITHDRAW_SHOW_BALANCE, 6 TRANSACTION, 7 DEPOSIT).
- `amount` output 11: assembled amount.
- `destination_acc` output 12: assembled destination account.
- `req_valid` output 1: a request is pending on the output fields.
- `exit` output 1: one-cycle session-end pulse.
- `entry_error` output 1: one-cycle pulse when an entry is rejected.

## Operation
- States: S_ACC, S_PIN, S_MENU, S_AMOUNT, S_DEST, S_ISSUE.
- After reset the block is in S_ACC.
- **Digit entry.** Each digit updates the shared accumulator as `acc_next = acc*10 + digit`, computed 14 bits wide.
  - A field takes at most 4 digits (S_PIN and S_MENU take 1).
  - A digit beyond the field limit is ignored and pulses `entry_error`.
- **CLEAR.** Zeroes the accumulator and the digit count; the state is unchanged.
- **ENTER with zero digits.** Pulses `entry_error`; the state is unchanged.
- **ENTER range checks.** On failure the block pulses `entry_error`, clears the accumulator and stays in the state. Limits:
  - S_ACC and S_DEST: value ≤ 4095.
  - S_PIN: value ≤ 9.
  - S_AMOUNT: value ≤ 2047.
  - S_MENU: value in 3..7.
- **Successful ENTER.** Latches the value into the field output, then transitions:
  - S_ACC → S_PIN.
  - S_PIN → S_MENU.
  - S_MENU with option 3 → S_ISSUE.
  - S_MENU with option 4–7 → S_AMOUNT.
  - S_AMOUNT with option 6 → S_DEST, otherwise → S_ISSUE.
  - S_DEST → S_ISSUE.
- **S_ISSUE.** `req_valid`=1 and all field outputs are frozen.
  - When `req_ready`=1 the block drops `req_valid` and goes to S_MENU with the accumulator cleared.
  - `acc_number` and `pin` are retained for the next operation.
- **CANCEL (any state, including S_ISSUE).**
  - Pulses `exit`, drops `req_valid`, and zeroes all field outputs and the accumulator.
  - Next state is S_ACC.
- Keys other than CANCEL arriving in S_ISSUE are dropped silently.

## Timing
- Reset value of every output is 0: `acc_number`, `pin`, `menu_option`, `amount`, `destination_acc`, `req_valid`, `exit`, `entry_error`.
- All outputs are registered.
- `req_valid` rises on the cycle after the accepting ENTER edge.
- `req_valid` stays high until the first edge with `req_ready`=1 and falls on that edge.
  - If `req_ready` is already high when `req_valid` rises, the handshake completes on the next edge, giving a minimum of 1 cycle high.
- `exit` and `entry_error` are high for exactly one cycle after the offending or triggering key edge.
- CANCEL together with `req_ready`=1 on the same edge: CANCEL wins. The request is considered not accepted by this block, and `exit` pulses.
- Reset takes priority over every key and handshake. Reset during S_ISSUE drops `req_valid` on the next edge.
- Back-to-back `key_valid` cycles are all processed; there is no internal queue.

## Configuration
- `ATM_KEYPAD_TIMEOUT_EN` defined:
  - A counter counts cycles without `key_valid` in every state except S_ACC and S_ISSUE.
  - When it reaches `TIMEOUT_CYCLES` the block behaves exactly as on CANCEL (`exit` pulse, return to S_ACC).
  - The counter reloads on any `key_valid` and on every state change.
- `ATM_KEYPAD_TIMEOUT_EN` not defined: no counter is built, `TIMEOUT_CYCLES` is unused, and a session persists indefinitely.

## Structure
- Shared package `atm_pkg`:
  - menu option codes (BALANCE=3 … DEPOSIT=7);
  - key codes (KEY_ENTER, KEY_CLEAR, KEY_CANCEL);
  - front-end state enum;
  - limits ACC_MAX=4095, AMOUNT_MAX=2047, PIN_MAX=9.
- One sub-module, `decimal_accumulator`: holds the 14-bit value and 3-bit digit count, with inputs digit/clear/max_digits and outputs value and overflow (digit limit exceeded).

## Test plan
- Keys 2,7,4,9,ENTER,3,ENTER,3,ENTER → `req_valid` high with `acc_number`=2749, `pin`=3, `menu_option`=3. With `req_ready` held high, `req_valid` is high for 1 cycle, then the state is S_MENU.
- After login, 6,ENTER,1,5,0,ENTER,2,1,7,5,ENTER → request with `menu_option`=6, `amount`=150, `destination_acc`=2175.
- Amount 2,0,4,8,ENTER → `entry_error` pulse, no request. Then 2,0,4,7,ENTER → request with `amount`=2047.
- Account 5,0,0,0,ENTER → `entry_error` and the state stays S_ACC. A 5th digit pulses `entry_error`; CLEAR then 2,1,2,5,ENTER is accepted.
- CANCEL while `req_valid`=1 and `req_ready`=0 → `exit` pulse, `req_valid`=0, all fields 0, state S_ACC.
- With `ATM_KEYPAD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20: idle 20 cycles in S_MENU → `exit` pulse and return to S_ACC. Without the macro, the same stimulus gives no `exit`.
